// File: rtl/z80_opcode_tracker_if.sv
// Bus bundle between the Z80 side (master) and the opcode tracker (slave).
// CNT_WIDTH must match the tracker's counter width.
interface z80_opcode_tracker_if #(
   parameter int unsigned CNT_WIDTH = 16
);
   logic [7:0]           data;
   logic                 m1_n;
   logic                 iorq_n;
   logic                 count_clr;
   logic                 at_boundary;
   logic                 is_retn;
   logic                 is_reti;
   logic                 boundary_stb;
   logic                 intack_stb;
   logic [CNT_WIDTH-1:0] instr_count;

   modport master (
      output data, m1_n, iorq_n, count_clr,
      input  at_boundary, is_retn, is_reti, boundary_stb, intack_stb, instr_count
   );

   modport slave (
      input  data, m1_n, iorq_n, count_clr,
      output at_boundary, is_retn, is_reti, boundary_stb, intack_stb, instr_count
   );
endinterface

// File: rtl/z80_opcode_tracker.sv
// Z80 instruction-boundary tracker: follows CB/ED/DD/FD prefixes across M1 fetches,
// flags completed instructions, decodes RETN/RETI. Optional macro: OPCODE_RETN_ALIAS_EN.
module z80_opcode_tracker #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input logic                 clk,
   input logic                 rst,
   z80_opcode_tracker_if.slave bus
);
   localparam int unsigned LAST = SYNC_STAGES - 1;

   localparam logic [7:0] OP_CB   = 8'hCB;
   localparam logic [7:0] OP_ED   = 8'hED;
   localparam logic [7:0] OP_DD   = 8'hDD;
   localparam logic [7:0] OP_FD   = 8'hFD;
   localparam logic [7:0] OP_RETN = 8'h45;
   localparam logic [7:0] OP_RETI = 8'h4D;

   typedef enum logic [1:0] {
      ST_BASE,
      ST_IDX,
      ST_CB,
      ST_ED
   } state_t;

   state_t state;

   logic [SYNC_STAGES-1:0]      m1_sync;
   logic [SYNC_STAGES-1:0]      iorq_sync;
   logic [SYNC_STAGES-1:0][7:0] data_sync;
   logic [SYNC_STAGES:0]        m1_chain_c;
   logic [SYNC_STAGES:0]        iorq_chain_c;
   logic [SYNC_STAGES:0][7:0]   data_chain_c;

   logic       m1_s;
   logic       iorq_s;
   logic [7:0] data_s;
   logic       m1_prev;
   logic [7:0] op;
   logic       ack;

   logic end_c;
   logic decode_c;
   logic prefix_c;
   logic boundary_c;
   logic retn_c;
   logic reti_c;

   // Second byte of an ED pair that returns from NMI.
   function automatic logic retn_op(input logic [7:0] b);
`ifdef OPCODE_RETN_ALIAS_EN
      return (b == 8'h45) || (b == 8'h55) || (b == 8'h5D) || (b == 8'h65) ||
             (b == 8'h6D) || (b == 8'h75) || (b == 8'h7D);
`else
      return (b == OP_RETN);
`endif
   endfunction

   // Chain input concatenated in front so the shift works for any depth including 1.
   assign m1_chain_c   = {m1_sync, bus.m1_n};
   assign iorq_chain_c = {iorq_sync, bus.iorq_n};
   assign data_chain_c = {data_sync, bus.data};

   always_ff @(posedge clk) begin
      if (rst) begin
         m1_sync   <= '1;
         iorq_sync <= '1;
         data_sync <= '0;
      end else begin
         m1_sync   <= m1_chain_c[SYNC_STAGES-1:0];
         iorq_sync <= iorq_chain_c[SYNC_STAGES-1:0];
         data_sync <= data_chain_c[SYNC_STAGES-1:0];
      end
   end

   assign m1_s   = m1_sync[LAST];
   assign iorq_s = iorq_sync[LAST];
   assign data_s = data_sync[LAST];

   assign end_c      = m1_s & ~m1_prev;
   assign decode_c   = end_c & ~ack;
   assign boundary_c = decode_c & ~prefix_c;
   assign retn_c     = (state == ST_ED) && retn_op(op);
   assign reti_c     = (state == ST_ED) && (op == OP_RETI);

   // Bytes that extend the current instruction instead of completing it.
   always_comb begin
      prefix_c = 1'b0;
      case (state)
         ST_BASE: prefix_c = (op == OP_CB) || (op == OP_ED) || (op == OP_DD) || (op == OP_FD);
         ST_IDX:  prefix_c = (op == OP_DD) || (op == OP_FD) || (op == OP_ED);
         default: prefix_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_BASE;
         m1_prev          <= 1'b1;
         op               <= '0;
         ack              <= 1'b0;
         bus.at_boundary  <= 1'b0;
         bus.is_retn      <= 1'b0;
         bus.is_reti      <= 1'b0;
         bus.boundary_stb <= 1'b0;
         bus.intack_stb   <= 1'b0;
         bus.instr_count  <= '0;
      end else begin
         m1_prev          <= m1_s;
         bus.boundary_stb <= boundary_c;
         bus.intack_stb   <= end_c & ack;

         // Last sample before M1 rises is the one decoded.
         if (!m1_s) begin
            op  <= data_s;
            ack <= ~iorq_s;
         end

         if (decode_c) begin
            bus.at_boundary <= ~prefix_c;
            bus.is_retn     <= retn_c;
            bus.is_reti     <= reti_c;
            case (state)
               ST_BASE: begin
                  if (op == OP_CB)                       state <= ST_CB;
                  else if (op == OP_ED)                  state <= ST_ED;
                  else if ((op == OP_DD) || (op == OP_FD)) state <= ST_IDX;
                  else                                   state <= ST_BASE;
               end
               // DDCB/FDCB tail bytes are plain reads, so CB completes here.
               ST_IDX: begin
                  if ((op == OP_DD) || (op == OP_FD)) state <= ST_IDX;
                  else if (op == OP_ED)                state <= ST_ED;
                  else                                 state <= ST_BASE;
               end
               default: state <= ST_BASE;
            endcase
         end

         if (bus.count_clr)
            bus.instr_count <= '0;
         else if (boundary_c)
            bus.instr_count <= bus.instr_count + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_z80_opcode_tracker.sv
// Bench for z80_opcode_tracker: directed test-plan steps then random fetch streams
// compared against a prefix-queue model of Z80 instruction structure.
module tb_z80_opcode_tracker;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned CNT_WIDTH   = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   z80_opcode_tracker_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

   z80_opcode_tracker #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: bytes of the instruction fetched so far, plus the visible levels.
   logic [7:0] pend[$];
   bit         m_bnd, m_retn, m_reti;
   int         m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit retn_byte(input logic [7:0] b);
`ifdef OPCODE_RETN_ALIAS_EN
      return b inside {8'h45, 8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D};
`else
      return b == 8'h45;
`endif
   endfunction

   task automatic model_reset();
      pend.delete();
      m_bnd = 0; m_retn = 0; m_reti = 0; m_cnt = 0;
   endtask

   task automatic model_step(input logic [7:0] b, input bit ack, input bit clr,
                             output bit exp_bstb, output bit exp_istb);
      bit         complete;
      logic [7:0] last;
      exp_bstb = 0;
      exp_istb = ack;
      if (!ack) begin
         last = (pend.size() != 0) ? pend[$] : 8'h00;
         if (pend.size() == 0)
            complete = !(b inside {8'hCB, 8'hED, 8'hDD, 8'hFD});
         else if (last == 8'hDD || last == 8'hFD)
            complete = !(b inside {8'hDD, 8'hFD, 8'hED});
         else
            complete = 1;
         exp_bstb = complete;
         m_bnd    = complete;
         if (complete) begin
            m_retn = (pend.size() != 0) && last == 8'hED && retn_byte(b);
            m_reti = (pend.size() != 0) && last == 8'hED && b == 8'h4D;
            m_cnt  = (m_cnt + 1) % (1 << CNT_WIDTH);
            pend.delete();
         end else begin
            m_retn = 0;
            m_reti = 0;
            pend.push_back(b);
         end
      end
      if (clr) m_cnt = 0;
   endtask

   task automatic check_levels(input string tag);
      chk({tag, ".at_boundary"}, 32'(bus.at_boundary), 32'(m_bnd));
      chk({tag, ".is_retn"},     32'(bus.is_retn),     32'(m_retn));
      chk({tag, ".is_reti"},     32'(bus.is_reti),     32'(m_reti));
      chk({tag, ".count"},       32'(bus.instr_count), 32'(m_cnt));
   endtask

   // One M1 fetch; count_clr (if requested) spans the edge the strobe is produced on.
   task automatic fetch(input logic [7:0] b, input bit ack, input bit clr, input string tag);
      bit eb, ei;
      @(negedge clk);
      bus.data   = b;
      bus.m1_n   = 1'b0;
      bus.iorq_n = !ack;
      repeat (4) @(negedge clk);
      bus.m1_n   = 1'b1;
      bus.iorq_n = 1'b1;
      model_step(b, ack, clr, eb, ei);
      @(posedge clk);
      repeat (SYNC_STAGES - 1) @(posedge clk);
      #1;
      chk({tag, ".early_stb"}, 32'({bus.boundary_stb, bus.intack_stb}), 32'(0));
      bus.data = 8'($urandom);
      if (clr) bus.count_clr = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, ".boundary_stb"}, 32'(bus.boundary_stb), 32'(eb));
      chk({tag, ".intack_stb"},   32'(bus.intack_stb),   32'(ei));
      check_levels(tag);
      @(posedge clk);
      #1;
      chk({tag, ".stb_end"}, 32'({bus.boundary_stb, bus.intack_stb}), 32'(0));
      bus.count_clr = 1'b0;
      chk({tag, ".count_hold"}, 32'(bus.instr_count), 32'(m_cnt));
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst        = 1'b1;
      bus.m1_n   = 1'b1;
      bus.iorq_n = 1'b1;
      bus.count_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk({tag, ".stb"}, 32'({bus.boundary_stb, bus.intack_stb}), 32'(0));
      check_levels(tag);
   endtask

   initial begin
      logic [7:0] pool [10];
      logic [7:0] b;
      pool = '{8'hCB, 8'hED, 8'hDD, 8'hFD, 8'h45, 8'h4D, 8'h55, 8'h7D, 8'h00, 8'h3E};
      rst = 1'b1;
      bus.data = 8'h00; bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.count_clr = 1'b0;
      model_reset();

      do_reset("reset");
      fetch(8'h3E, 0, 0, "ld_a");
      fetch(8'hDD, 0, 0, "ddcb_dd");
      fetch(8'hCB, 0, 0, "ddcb_cb");
      fetch(8'hDD, 0, 0, "retn_dd");
      fetch(8'hFD, 0, 0, "retn_fd");
      fetch(8'hED, 0, 0, "retn_ed");
      fetch(8'h45, 0, 0, "retn_45");
      fetch(8'h00, 0, 0, "retn_clear");
      fetch(8'hED, 0, 0, "alias_ed");
      fetch(8'h55, 0, 0, "alias_55");
      fetch(8'hED, 0, 0, "reti_ed");
      fetch(8'h4D, 0, 0, "reti_4d");
      fetch(8'hCB, 0, 0, "ack_cb");
      fetch(8'hFF, 1, 0, "ack_ff");
      fetch(8'h00, 0, 0, "ack_done");
      fetch(8'h3E, 0, 1, "clr_same");
      fetch(8'h00, 0, 0, "after_clr");

      // Idle bus produces no events.
      repeat (20) @(posedge clk);
      #1;
      chk("idle.stb", 32'({bus.boundary_stb, bus.intack_stb}), 32'(0));
      check_levels("idle");

      do_reset("wrap_reset");
      for (int i = 0; i < 16; i++) fetch(8'h00, 0, 0, "wrap");
      chk("wrap.zero", 32'(bus.instr_count), 32'(0));

      fetch(8'hDD, 0, 0, "midrst_dd");
      do_reset("midrst_reset");
      fetch(8'h3E, 0, 0, "midrst_3e");

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 39) == 0) do_reset("rnd_reset");
         b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
         fetch(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
